// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: word-addressed RAM, GPIO port and compare timer
// sharing one address space, with a combinational read path back to the core.
module dmem_mmio #(
   parameter int BUS_WIDTH = 32,
   parameter int DEPTH     = 64,
   parameter int GPIO_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_mem,
   input  logic [BUS_WIDTH-1:0] addr_mem,
   input  logic [BUS_WIDTH-1:0] wr_mem_data,
   output logic [BUS_WIDTH-1:0] mem_data,
   input  logic [GPIO_W-1:0]    gpio_in,
   output logic [GPIO_W-1:0]    gpio_out,
   output logic                 timer_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [BUS_WIDTH-1:0] RAM_LIMIT = BUS_WIDTH'(DEPTH * 4);
   // MMIO block occupies 0xFFFF_FF00..0xFFFF_FF1F; addr[4:2] selects the register
   localparam logic [BUS_WIDTH-6:0] MMIO_BASE = 27'h7FF_FFF8;

   localparam logic [2:0] REG_GPIO_OUT = 3'd0;
   localparam logic [2:0] REG_GPIO_IN  = 3'd1;
   localparam logic [2:0] REG_TMR_CNT  = 3'd2;
   localparam logic [2:0] REG_TMR_CMP  = 3'd3;
   localparam logic [2:0] REG_TMR_CTRL = 3'd4;
   localparam logic [2:0] REG_TMR_STAT = 3'd5;

   logic [BUS_WIDTH-1:0] r_ram [DEPTH];
   logic [GPIO_W-1:0]    r_gpio_out;
   logic [GPIO_W-1:0]    r_sync1;
   logic [GPIO_W-1:0]    r_sync2;
   logic [BUS_WIDTH-1:0] r_cnt;
   logic [BUS_WIDTH-1:0] r_cmp;
   logic [2:0]           r_ctrl;
   logic                 r_match;

   logic                 w_sel_ram;
   logic                 w_sel_mmio;
   logic [AW-1:0]        w_word;
   logic [2:0]           w_reg;
   logic                 w_wr_gpio;
   logic                 w_wr_cnt;
   logic                 w_wr_cmp;
   logic                 w_wr_ctrl;
   logic                 w_wr_stat;
   logic                 w_hit;
   logic [BUS_WIDTH-1:0] w_cnt_nxt;
   logic                 w_match_nxt;
   logic [BUS_WIDTH-1:0] w_rd;
   logic                 w_unused;

   assign w_sel_ram  = (addr_mem < RAM_LIMIT);
   assign w_sel_mmio = (addr_mem[BUS_WIDTH-1:5] == MMIO_BASE);
   assign w_word     = addr_mem[AW+1:2];
   assign w_reg      = addr_mem[4:2];
   assign w_unused   = &{1'b0, addr_mem[1:0]};

   assign w_wr_gpio = we_mem & w_sel_mmio & (w_reg == REG_GPIO_OUT);
   assign w_wr_cnt  = we_mem & w_sel_mmio & (w_reg == REG_TMR_CNT);
   assign w_wr_cmp  = we_mem & w_sel_mmio & (w_reg == REG_TMR_CMP);
   assign w_wr_ctrl = we_mem & w_sel_mmio & (w_reg == REG_TMR_CTRL);
   assign w_wr_stat = we_mem & w_sel_mmio & (w_reg == REG_TMR_STAT);

   // Match is judged on pre-edge count, compare value and enable
   assign w_hit = r_ctrl[0] & (r_cnt == r_cmp);

   // Counter next value: CPU load beats auto-clear, which beats increment
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr_cnt) begin
         w_cnt_nxt = wr_mem_data;
      end else if (w_hit && r_ctrl[1]) begin
         w_cnt_nxt = '0;
      end else if (r_ctrl[0]) begin
         w_cnt_nxt = r_cnt + BUS_WIDTH'(1);
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Sticky match flag: a new match wins over a same-cycle write-1-to-clear
   always_comb begin
      w_match_nxt = r_match;
      if (w_hit) begin
         w_match_nxt = 1'b1;
      end else if (w_wr_stat && wr_mem_data[0]) begin
         w_match_nxt = 1'b0;
      end else begin
         w_match_nxt = r_match;
      end
   end

   // Data RAM: contents survive reset, writes are blocked while reset is low
   always_ff @(posedge clk) begin
      if (rst && we_mem && w_sel_ram) begin
         r_ram[w_word] <= wr_mem_data;
      end
   end

   // Peripheral registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_gpio_out <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_cnt      <= '0;
         r_cmp      <= '1;
         r_ctrl     <= 3'd0;
         r_match    <= 1'b0;
      end else begin
         r_sync1 <= gpio_in;
         r_sync2 <= r_sync1;
         r_cnt   <= w_cnt_nxt;
         r_match <= w_match_nxt;
         if (w_wr_gpio) begin
            r_gpio_out <= wr_mem_data[GPIO_W-1:0];
         end
         if (w_wr_cmp) begin
            r_cmp <= wr_mem_data;
         end
         if (w_wr_ctrl) begin
            r_ctrl <= wr_mem_data[2:0];
         end
      end
   end

   // Combinational read mux; unmapped addresses read as zero
   always_comb begin
      w_rd = '0;
      if (w_sel_ram) begin
         w_rd = r_ram[w_word];
      end else if (w_sel_mmio) begin
         case (w_reg)
            REG_GPIO_OUT: w_rd = BUS_WIDTH'(r_gpio_out);
            REG_GPIO_IN:  w_rd = BUS_WIDTH'(r_sync2);
            REG_TMR_CNT:  w_rd = r_cnt;
            REG_TMR_CMP:  w_rd = r_cmp;
            REG_TMR_CTRL: w_rd = BUS_WIDTH'(r_ctrl);
            REG_TMR_STAT: w_rd = BUS_WIDTH'(r_match);
            default:      w_rd = '0;
         endcase
      end else begin
         w_rd = '0;
      end
   end

   assign mem_data  = w_rd;
   assign gpio_out  = r_gpio_out;
   assign timer_irq = r_match & r_ctrl[2];

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed vector table, a reset-mid-run
// sequence, and randomized traffic checked against a behavioural model.
module tb_dmem_mmio;

   localparam int DEPTH = 64;

   logic        clk;
   logic        rst;
   logic        we_mem;
   logic [31:0] addr_mem;
   logic [31:0] wr_mem_data;
   logic [31:0] mem_data;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   int n_cmp;
   int n_err;

   dmem_mmio #(.BUS_WIDTH(32), .DEPTH(DEPTH), .GPIO_W(8)) dut (
      .clk(clk), .rst(rst), .we_mem(we_mem), .addr_mem(addr_mem),
      .wr_mem_data(wr_mem_data), .mem_data(mem_data), .gpio_in(gpio_in),
      .gpio_out(gpio_out), .timer_irq(timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   logic [31:0] m_mem [DEPTH];
   logic [7:0]  m_gpio_out;
   logic [7:0]  m_s1;
   logic [7:0]  m_s2;
   logic [31:0] m_cnt;
   logic [31:0] m_cmp;
   logic [2:0]  m_ctrl;
   logic        m_match;

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] wa;
      wa = a & 32'hFFFF_FFFC;
      if (a < 32'(DEPTH * 4)) return m_mem[a >> 2];
      case (wa)
         32'hFFFF_FF00: return {24'd0, m_gpio_out};
         32'hFFFF_FF04: return {24'd0, m_s2};
         32'hFFFF_FF08: return m_cnt;
         32'hFFFF_FF0C: return m_cmp;
         32'hFFFF_FF10: return {29'd0, m_ctrl};
         32'hFFFF_FF14: return {31'd0, m_match};
         default:       return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] g);
      logic [31:0] wa;
      logic [31:0] n_cnt;
      logic        n_match;
      bit          fire;
      wa = a & 32'hFFFF_FFFC;
      if (!r) begin
         m_gpio_out = 8'd0; m_s1 = 8'd0; m_s2 = 8'd0;
         m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 3'd0; m_match = 1'b0;
      end else begin
         fire = (m_ctrl[0] == 1'b1) && (m_cnt == m_cmp);
         if (we && wa == 32'hFFFF_FF08)      n_cnt = d;
         else if (fire && m_ctrl[1])         n_cnt = 32'd0;
         else if (m_ctrl[0])                 n_cnt = m_cnt + 32'd1;
         else                                n_cnt = m_cnt;
         n_match = m_match;
         if (we && wa == 32'hFFFF_FF14 && d[0]) n_match = 1'b0;
         if (fire) n_match = 1'b1;
         if (we && a < 32'(DEPTH * 4)) m_mem[a >> 2] = d;
         if (we && wa == 32'hFFFF_FF00) m_gpio_out = d[7:0];
         if (we && wa == 32'hFFFF_FF0C) m_cmp = d;
         if (we && wa == 32'hFFFF_FF10) m_ctrl = d[2:0];
         m_cnt = n_cnt;
         m_match = n_match;
         m_s2 = m_s1;
         m_s1 = g;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [7:0] g);
      rst = r; we_mem = we; addr_mem = a; wr_mem_data = d; gpio_in = g;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(rst, we_mem, addr_mem, wr_mem_data, gpio_in);
      @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  gin;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [7:0]  exp_gpio;
      logic        exp_irq;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                               input logic [7:0] g, input logic c, input logic [31:0] e,
                               input logic [7:0] eg, input logic ei);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.gin = g;
      v.chk_rd = c; v.exp_rd = e; v.exp_gpio = eg; v.exp_irq = ei;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      n_cmp = 0;
      n_err = 0;
      // RAM, aliasing and GPIO
      tbl.push_back(mk(1'b0, 32'hFFFF_FF0C, 32'd0,          8'h00, 1'b1, 32'hFFFF_FFFF, 8'h00, 1'b0));
      tbl.push_back(mk(1'b1, 32'h0000_0010, 32'h1111_1111,  8'h00, 1'b0, 32'd0,         8'h00, 1'b0));
      tbl.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  8'h00, 1'b1, 32'h1111_1111, 8'h00, 1'b0));
      tbl.push_back(mk(1'b0, 32'h0000_0010, 32'd0,          8'h00, 1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0));
      tbl.push_back(mk(1'b0, 32'h0000_0013, 32'd0,          8'h00, 1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0));
      tbl.push_back(mk(1'b1, 32'h0000_0000, 32'h0000_000A,  8'h00, 1'b0, 32'd0,         8'h00, 1'b0));
      tbl.push_back(mk(1'b1, 32'h0000_0200, 32'h0000_0055,  8'h00, 1'b1, 32'd0,         8'h00, 1'b0));
      tbl.push_back(mk(1'b0, 32'h0000_0200, 32'd0,          8'h00, 1'b1, 32'd0,         8'h00, 1'b0));
      tbl.push_back(mk(1'b0, 32'h0000_0000, 32'd0,          8'h00, 1'b1, 32'h0000_000A, 8'h00, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF00, 32'h0000_01A5,  8'h00, 1'b1, 32'd0,         8'h00, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF00, 32'd0,          8'h00, 1'b1, 32'h0000_00A5, 8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF04, 32'd0,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF04, 32'd0,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF04, 32'd0,          8'h3C, 1'b1, 32'h0000_003C, 8'hA5, 1'b0));
      // Timer auto-clear, W1C, clear/set collision
      tbl.push_back(mk(1'b1, 32'hFFFF_FF0C, 32'd5,          8'h3C, 1'b1, 32'hFFFF_FFFF, 8'hA5, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF10, 32'd7,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      for (int k = 0; k <= 5; k++)
         tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,       8'h3C, 1'b1, 32'(k),        8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b1));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b1));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF14, 32'd1,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b1));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF14, 32'd0,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'd4,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF14, 32'd1,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF14, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b1));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF14, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b1));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF14, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b1));
      // Wrap, CPU-load priority, IRQ_EN gating
      tbl.push_back(mk(1'b1, 32'hFFFF_FF10, 32'd0,          8'h3C, 1'b1, 32'd7,         8'hA5, 1'b1));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF14, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF08, 32'hFFFF_FFFE,  8'h3C, 1'b1, 32'd4,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF0C, 32'h0000_0010,  8'h3C, 1'b1, 32'd5,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF10, 32'd1,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'hFFFF_FFFE, 8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'hFFFF_FFFF, 8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b1, 32'hFFFF_FF08, 32'h0000_0100,  8'h3C, 1'b1, 32'd2,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'h0000_0100, 8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF08, 32'd0,          8'h3C, 1'b1, 32'h0000_0101, 8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF10, 32'd0,          8'h3C, 1'b1, 32'd1,         8'hA5, 1'b0));
      tbl.push_back(mk(1'b0, 32'hFFFF_FF18, 32'd0,          8'h3C, 1'b1, 32'd0,         8'hA5, 1'b0));

      // Reset held low for two edges
      drive(1'b0, 1'b0, 32'd0, 32'd0, 8'h00);
      tick();
      tick();
      chk("reset gpio_out", {24'd0, gpio_out}, 32'd0);
      chk("reset irq", {31'd0, timer_irq}, 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].gin);
         if (tbl[i].chk_rd) chk($sformatf("row%0d rd", i), mem_data, tbl[i].exp_rd);
         chk($sformatf("row%0d gpio", i), {24'd0, gpio_out}, {24'd0, tbl[i].exp_gpio});
         chk($sformatf("row%0d irq", i), {31'd0, timer_irq}, {31'd0, tbl[i].exp_irq});
         tick();
      end

      // Reset in the middle of a running timer with MATCH set
      drive(1'b1, 1'b1, 32'hFFFF_FF08, 32'h0000_000E, 8'h3C); tick();
      drive(1'b1, 1'b1, 32'hFFFF_FF10, 32'd7, 8'h3C);         tick();
      drive(1'b1, 1'b0, 32'hFFFF_FF08, 32'd0, 8'h3C);
      chk("mid cnt 0F", mem_data, 32'h0000_000F);             tick();
      chk("mid cnt 10", mem_data, 32'h0000_0010);             tick();
      drive(1'b1, 1'b0, 32'hFFFF_FF14, 32'd0, 8'h3C);
      chk("mid match", mem_data, 32'd1);
      chk("mid irq", {31'd0, timer_irq}, 32'd1);              tick();
      drive(1'b0, 1'b1, 32'hFFFF_FF08, 32'h0000_0055, 8'h3C); tick();
      drive(1'b1, 1'b0, 32'hFFFF_FF08, 32'd0, 8'h3C);
      chk("rst cnt", mem_data, 32'd0);
      chk("rst irq", {31'd0, timer_irq}, 32'd0);
      chk("rst gpio_out", {24'd0, gpio_out}, 32'd0);          tick();
      drive(1'b1, 1'b0, 32'hFFFF_FF14, 32'd0, 8'h3C);
      chk("rst match", mem_data, 32'd0);                      tick();
      drive(1'b1, 1'b0, 32'hFFFF_FF0C, 32'd0, 8'h3C);
      chk("rst cmp", mem_data, 32'hFFFF_FFFF);                tick();
      drive(1'b1, 1'b0, 32'h0000_0010, 32'd0, 8'h3C);
      chk("ram kept", mem_data, 32'hDEAD_BEEF);               tick();

      // Give every RAM word a known value, then random traffic vs the model
      for (int w = 0; w < DEPTH; w++) begin
         drive(1'b1, 1'b1, 32'(w * 4), $urandom, 8'h3C);
         tick();
      end
      for (int n = 0; n < 3000; n++) begin
         logic        r;
         logic        we;
         logic [31:0] a;
         logic [31:0] d;
         logic [7:0]  g;
         int          sel;
         r   = ($urandom_range(0, 199) != 0);
         we  = ($urandom_range(0, 2) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 4)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
         else if (sel < 8) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
         else if (sel < 9) a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FF18 + 32'($urandom_range(0, 9) * 4)
                                                           : 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
         else              a = $urandom;
         d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
         g = (n % 5 == 0) ? 8'($urandom) : gpio_in;
         drive(r, we, a, d, g);
         chk($sformatf("rnd%0d rd @%h", n, a), mem_data, m_read(a));
         chk($sformatf("rnd%0d gpio", n), {24'd0, gpio_out}, {24'd0, m_gpio_out});
         chk($sformatf("rnd%0d irq", n), {31'd0, timer_irq}, {31'd0, m_match & m_ctrl[2]});
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
